// File: rtl/wb_pkg.sv
// Shared definitions for the RV32IM writeback stage.
// Holds the W-stage source indices, the register address width, the canonical
// late-result entry layout and a small helper for "real" destination registers.
package wb_pkg;

  // W-stage result source indices (ResultSrcW encoding)
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_MD  = 3;

  // Register-file address width
  localparam int REG_AW = 5;

  // Native datapath width of the RV32IM core
  localparam int WB_XLEN = 32;

  // Late-result queue entry: valid flag, destination and value
  typedef struct packed {
    logic                 valid;
    logic [REG_AW-1:0]    rd;
    logic [WB_XLEN-1:0]   data;
  } late_entry_t;

  // True when rd names an architectural register other than x0
  function automatic logic is_real_rd(input logic [REG_AW-1:0] rd);
    return (rd != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/wb_late_queue.sv
// Late-result FIFO for long-latency (mul/div) results.
// Each slot keeps its own valid bit so that a younger pipeline write to the
// same rd can kill a queued result in place; killed slots still occupy space
// and are simply discarded when they reach the head.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push/push_rd/data   enqueue at tail (ignored when full and not popping)
//   pop                 dequeue head (ignored when empty)
//   kill/kill_rd        invalidate every slot whose rd matches kill_rd
//   head_valid/rd/data  head slot contents; head_valid is low when empty
//   count               occupancy including killed slots
//   full, empty         occupancy flags
module wb_late_queue
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [XLEN-1:0]   push_data,
  input  logic              pop,
  input  logic              kill,
  input  logic [REG_AW-1:0] kill_rd,
  output logic              head_valid,
  output logic [REG_AW-1:0] head_rd,
  output logic [XLEN-1:0]   head_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DEPTH-1:0]  valid_r;
  logic [REG_AW-1:0] rd_r   [DEPTH];
  logic [XLEN-1:0]   data_r [DEPTH];
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;

  logic pop_ok_s;
  logic push_ok_s;

  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));

  // A full queue may accept a push only in the cycle it also pops
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  assign head_valid = !empty && valid_r[head_r];
  assign head_rd    = rd_r[head_r];
  assign head_data  = data_r[head_r];
  assign count      = count_r;

  // Slot state, pointers and occupancy; kill, then pop, then push so that a
  // push into the slot being popped (full queue) wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {DEPTH{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= {REG_AW{1'b0}};
        data_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && (rd_r[i] == kill_rd)) begin
          valid_r[i] <= 1'b0;
        end
      end
      if (pop_ok_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PW'(1);
      end
      if (push_ok_s) begin
        valid_r[tail_r] <= 1'b1;
        rd_r[tail_r]    <= push_rd;
        data_r[tail_r]  <= push_data;
        tail_r          <= tail_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// RV32IM writeback stage: selects the W-stage result, merges out-of-band
// long-latency results through a small queue and drives the single
// register-file write port one cycle later.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   RegWriteW, RdW      W-stage write enable and destination
//   ResultSrcW          W-stage source select
//   SrcDataW            flattened sources, source i at [i*XLEN +: XLEN]
//   late_valid/rd/data  long-latency result offer
//   late_ready          late result accepted this cycle when high
//   ResultW             combinational selected result (forwarding)
//   rf_we/waddr/wdata   registered register-file write port
//   lq_count            late queue occupancy
// Port priority: pipeline write, then queue head, then bypass of a late
// result into an empty queue. The pipeline instruction is always younger
// than any late result, so its write kills matching queued/incoming results.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 4,
  parameter int SELW     = 2,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteW,
  input  logic [REG_AW-1:0]         RdW,
  input  logic [SELW-1:0]           ResultSrcW,
  input  logic [NUM_SRC*XLEN-1:0]   SrcDataW,
  input  logic                      late_valid,
  input  logic [REG_AW-1:0]         late_rd,
  input  logic [XLEN-1:0]           late_data,
  output logic                      late_ready,
  output logic [XLEN-1:0]           ResultW,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic [XLEN-1:0]   result_s;
  logic              pipe_wr_s;
  logic              late_xfer_s;
  logic              late_keep_s;
  logic              pop_s;
  logic              head_write_s;
  logic              bypass_s;
  logic              push_s;

  logic              q_head_valid_s;
  logic [REG_AW-1:0] q_head_rd_s;
  logic [XLEN-1:0]   q_head_data_s;
  logic [CW-1:0]     q_count_s;
  logic              q_full_s;
  logic              q_empty_s;

  logic              rf_we_r;
  logic [REG_AW-1:0] rf_waddr_r;
  logic [XLEN-1:0]   rf_wdata_r;

  // W-stage source mux; out-of-range selects read as zero
  always_comb begin
    result_s = {XLEN{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(ResultSrcW) == i) begin
        result_s = SrcDataW[i*XLEN +: XLEN];
      end else begin
        result_s = result_s;
      end
    end
  end

  assign ResultW = result_s;

  // Write-port arbitration and queue control
  always_comb begin
    pipe_wr_s    = RegWriteW && is_real_rd(RdW);
    // Head is dequeued whenever the pipeline leaves the port free, even if
    // the head slot was killed, so dead slots drain without costing a write
    pop_s        = !pipe_wr_s && !q_empty_s;
    head_write_s = pop_s && q_head_valid_s;
    late_ready   = !q_full_s || pop_s;
    late_xfer_s  = late_valid && late_ready;
    // x0 results and results overwritten by the younger pipeline write are
    // accepted but go nowhere
    late_keep_s  = late_xfer_s && is_real_rd(late_rd) &&
                   !(pipe_wr_s && (late_rd == RdW));
    // Bypass only when nothing older remains queued: queue empty, or its
    // sole slot is a killed entry being popped right now
    bypass_s     = 1'b0;
    if (!pipe_wr_s && !head_write_s && late_keep_s) begin
      bypass_s = q_empty_s || (pop_s && (q_count_s == CW'(1)));
    end else begin
      bypass_s = 1'b0;
    end
    push_s       = late_keep_s && !bypass_s;
  end

  wb_late_queue #(
    .XLEN  (XLEN),
    .DEPTH (LQ_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push_s),
    .push_rd    (late_rd),
    .push_data  (late_data),
    .pop        (pop_s),
    .kill       (pipe_wr_s),
    .kill_rd    (RdW),
    .head_valid (q_head_valid_s),
    .head_rd    (q_head_rd_s),
    .head_data  (q_head_data_s),
    .count      (q_count_s),
    .full       (q_full_s),
    .empty      (q_empty_s)
  );

  // Register-file write port register; address/data hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_AW{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
    end else if (pipe_wr_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= RdW;
      rf_wdata_r <= result_s;
    end else if (head_write_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= q_head_rd_s;
      rf_wdata_r <= q_head_data_s;
    end else if (bypass_s) begin
      rf_we_r    <= 1'b1;
      rf_waddr_r <= late_rd;
      rf_wdata_r <= late_data;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign lq_count = q_count_s;

endmodule
